enhance_axis_packer: RTL and testbench



---
 rtl/enhance_pkg.sv | 9 +
 rtl/sync_stream_fifo.sv | 73 +++++++
 rtl/enhance_axis_packer.sv | 137 +++++++++++++
 tb/tb_enhance_axis_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/enhance_pkg.sv
// Shared constants and types for the enhancement-pipeline output stage.
package enhance_pkg;
    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;
    localparam int ENTRY_W      = WORD_W + 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} pack_state_t;
endpackage

// File: rtl/sync_stream_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through read port.
module sync_stream_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, mem_cnt;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             pop, push, load, bypass;

    // count_reg includes the word held in the output register
    always_comb begin
        full    = (count_reg == CW'(DEPTH));
        empty   = (count_reg == '0);
        pop     = out_valid_reg && rd_ready;
        push    = wr_en && (!full || pop);
        load    = !out_valid_reg || pop;
        mem_cnt = count_reg - CW'(out_valid_reg);
        bypass  = push && load && (mem_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (push && !bypass)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (push && !bypass)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (load) begin
                if (mem_cnt != '0) begin
                    out_data_reg  <= mem[rd_ptr_reg];
                    rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                    out_valid_reg <= 1'b1;
                end else if (push) begin
                    out_data_reg  <= wr_data;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end
            if (push && !pop)
                count_reg <= count_reg + CW'(1);
            else if (pop && !push)
                count_reg <= count_reg - CW'(1);
        end
    end

    assign rd_valid = out_valid_reg;
    assign rd_data  = out_data_reg;
endmodule

// File: rtl/enhance_axis_packer.sv
// Packs the 8-bit enhanced pixel stream four per word and streams framed
// words out over AXI4-Stream through a small backpressure FIFO.
module enhance_axis_packer import enhance_pkg::*; #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              sensor_state,
    input  logic              enhance_valid,
    input  logic [PIX_W-1:0]  enhance_dout,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [WORD_W-1:0] m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              overflow,
    output logic              frame_done
);
    localparam int WORDS_PER_LINE = IMG_WIDTH / PIX_PER_WORD;
    localparam int COL_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int IDX_W = $clog2(PIX_PER_WORD);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);

    pack_state_t        state_reg;
    logic               sensor_d_reg;
    logic [IDX_W-1:0]   byte_idx_reg;
    logic [COL_W-1:0]   col_w_reg;
    logic [ROW_W-1:0]   row_reg;
    logic               wr_en_reg, wr_last_reg;
    logic [ENTRY_W-1:0] wr_entry_reg;
    logic               frame_done_reg, overflow_reg;

    logic [(PIX_PER_WORD-1)*PIX_W-1:0] lanes;
    logic [IDX_W-1:0]   lane_sel;
    logic               lane_we, rise, line_end, frame_end, drop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;

    assign rise      = sensor_state && !sensor_d_reg;
    assign line_end  = (col_w_reg == COL_LAST);
    assign frame_end = line_end && (row_reg == ROW_LAST);
    // a pixel arriving with a frame-start edge becomes byte 0 of the new frame
    assign lane_sel  = rise ? '0 : byte_idx_reg;
    assign lane_we   = enhance_valid && (rise || state_reg == ACTIVE);
    assign drop      = wr_en_reg && fifo_full && !(fifo_empty == 1'b0 && m_axis_tready);

    genvar gi;
    generate
        for (gi = 0; gi < PIX_PER_WORD - 1; gi++) begin : g_lane
            logic [PIX_W-1:0] lane_reg;
            always_ff @(posedge s_axi_aclk) begin
                if (!s_axi_aresetn)
                    lane_reg <= '0;
                else if (lane_we && lane_sel == IDX_W'(gi))
                    lane_reg <= enhance_dout;
            end
            assign lanes[gi*PIX_W +: PIX_W] = lane_reg;
        end
    endgenerate

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_reg      <= IDLE;
            sensor_d_reg   <= 1'b0;
            byte_idx_reg   <= '0;
            col_w_reg      <= '0;
            row_reg        <= '0;
            wr_en_reg      <= 1'b0;
            wr_last_reg    <= 1'b0;
            wr_entry_reg   <= '0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            sensor_d_reg   <= sensor_state;
            wr_en_reg      <= 1'b0;
            frame_done_reg <= wr_en_reg && wr_last_reg;
            if (rise) begin
                state_reg    <= ACTIVE;
                byte_idx_reg <= enhance_valid ? IDX_W'(1) : '0;
                col_w_reg    <= '0;
                row_reg      <= '0;
            end else if (state_reg == ACTIVE && enhance_valid) begin
                if (byte_idx_reg == IDX_LAST) begin
                    byte_idx_reg <= '0;
                    wr_en_reg    <= 1'b1;
                    wr_last_reg  <= frame_end;
                    wr_entry_reg <= {(col_w_reg == '0 && row_reg == '0), line_end,
                                     enhance_dout, lanes};
                    // counters advance even if this word is later dropped
                    if (line_end) begin
                        col_w_reg <= '0;
                        if (row_reg == ROW_LAST) begin
                            row_reg   <= '0;
                            state_reg <= DONE;
                        end else begin
                            row_reg <= row_reg + ROW_W'(1);
                        end
                    end else begin
                        col_w_reg <= col_w_reg + COL_W'(1);
                    end
                end else begin
                    byte_idx_reg <= byte_idx_reg + IDX_W'(1);
                end
            end
            if (rise)
                overflow_reg <= 1'b0;
            else if (drop)
                overflow_reg <= 1'b1;
        end
    end

    sync_stream_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .wr_en    (wr_en_reg),
        .wr_data  (wr_entry_reg),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready),
        .rd_data  (fifo_dout)
    );

    assign m_axis_tuser = fifo_dout[ENTRY_W-1];
    assign m_axis_tlast = fifo_dout[ENTRY_W-2];
    assign m_axis_tdata = fifo_dout[WORD_W-1:0];
    assign overflow     = overflow_reg;
    assign frame_done   = frame_done_reg;
endmodule

// File: tb/tb_enhance_axis_packer.sv
// Scoreboard bench: small 8x2 frame instance plus a 640-wide instance for overflow.
module tb_enhance_axis_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sensor, ev, tready;
    logic [7:0]  dout;
    logic        tvalid, tuser, tlast, ovf, fd;
    logic [31:0] tdata;

    logic        b_sensor, b_ev, b_tready;
    logic [7:0]  b_dout;
    logic        b_tvalid, b_tuser, b_tlast, b_ovf, b_fd;
    logic [31:0] b_tdata;

    enhance_axis_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(2), .FIFO_DEPTH(16)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .sensor_state(sensor),
        .enhance_valid(ev), .enhance_dout(dout),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .overflow(ovf), .frame_done(fd));

    enhance_axis_packer #(.IMG_WIDTH(640), .IMG_HEIGHT(2), .FIFO_DEPTH(16)) dut_big (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .sensor_state(b_sensor),
        .enhance_valid(b_ev), .enhance_dout(b_dout),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready), .m_axis_tdata(b_tdata),
        .m_axis_tuser(b_tuser), .m_axis_tlast(b_tlast),
        .overflow(b_ovf), .frame_done(b_fd));

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int fd0 = 0;
    int b_cnt = 0;
    bit toggle_mode = 1'b0;
    logic [33:0] sb[$];
    logic [33:0] b_words[16];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    logic [33:0] exp_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fd === 1'b1) fd_cnt++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {tvalid, tuser, tlast, tdata}, {1'b1, prev_word});
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", {tuser, tlast, tdata});
                end else begin
                    exp_word = sb.pop_front();
                    chk("word", {tuser, tlast, tdata}, exp_word);
                    $display("word %0h tuser=%0b tlast=%0b", tdata, tuser, tlast);
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = tvalid;
                prev_word  = {tuser, tlast, tdata};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_tvalid && b_tready) begin
            if (b_cnt < 16) b_words[b_cnt] = {b_tuser, b_tlast, b_tdata};
            b_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) tready = ~tready;
    endtask

    task automatic pix(input logic [7:0] v);
        ev = 1'b1;
        dout = v;
        tick();
        ev = 1'b0;
    endtask

    task automatic frame_start();
        sensor = 1'b0;
        tick();
        sensor = 1'b1;
        tick();
    endtask

    task automatic expect_word(input logic u, input logic l, input logic [31:0] d);
        sb.push_back({u, l, d});
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        repeat (3) tick();
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tdata"}, tdata, 0);
        chk({tag, "_tuser"}, tuser, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_fd"}, fd, 0);
    endtask

    initial begin
        rst_n = 1'b0; sensor = 1'b0; ev = 1'b0; dout = '0; tready = 1'b1;
        b_sensor = 1'b0; b_ev = 1'b0; b_dout = '0; b_tready = 1'b0;
        repeat (3) tick();
        chk_reset_outs("reset");
        rst_n = 1'b1;
        tick();

        // basic 8x2 frame with latency check
        frame_start();
        fd0 = fd_cnt;
        expect_word(1, 0, 32'h03020100);
        expect_word(0, 1, 32'h07060504);
        expect_word(0, 0, 32'h0B0A0908);
        expect_word(0, 1, 32'h0F0E0D0C);
        for (int i = 0; i < 16; i++) begin
            ev = 1'b1;
            dout = 8'(i);
            tick();
            if (i == 3) chk("latency_1cyc", tvalid, 0);
            if (i == 4) chk("latency_2cyc", tvalid, 1);
        end
        ev = 1'b0;
        drain();
        chk("frame_done_basic", fd_cnt - fd0, 1);

        // same frame with tready toggling
        toggle_mode = 1'b1;
        frame_start();
        fd0 = fd_cnt;
        expect_word(1, 0, 32'h03020100);
        expect_word(0, 1, 32'h07060504);
        expect_word(0, 0, 32'h0B0A0908);
        expect_word(0, 1, 32'h0F0E0D0C);
        for (int i = 0; i < 16; i++) pix(8'(i));
        drain();
        toggle_mode = 1'b0;
        tready = 1'b1;
        chk("frame_done_toggle", fd_cnt - fd0, 1);

        // frame restart after 6 pixels; restart pixel becomes byte 0
        frame_start();
        fd0 = fd_cnt;
        expect_word(1, 0, 32'h23222120);
        expect_word(1, 0, 32'h33323130);
        expect_word(0, 1, 32'h37363534);
        expect_word(0, 0, 32'h3B3A3938);
        expect_word(0, 1, 32'h3F3E3D3C);
        for (int i = 0; i < 6; i++) pix(8'(8'h20 + i));
        sensor = 1'b0;
        tick();
        sensor = 1'b1;
        for (int i = 0; i < 16; i++) pix(8'(8'h30 + i));
        drain();
        chk("frame_done_restart", fd_cnt - fd0, 1);

        // reset with three words queued
        tready = 1'b0;
        frame_start();
        for (int i = 0; i < 12; i++) pix(8'(8'h40 + i));
        repeat (3) tick();
        chk("queued_valid", tvalid, 1);
        rst_n = 1'b0;
        sensor = 1'b0;
        tick();
        chk_reset_outs("midreset");
        rst_n = 1'b1;
        tready = 1'b1;
        repeat (10) tick();
        chk("post_reset_valid", tvalid, 0);

        // pixels in IDLE produce nothing
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) pix(8'(8'hA0 + i));
        repeat (3) tick();
        chk("idle_tvalid", tvalid, 0);
        chk("idle_ovf", ovf, 0);
        chk("idle_fd", fd_cnt - fd0, 0);

        // pixels in DONE produce nothing
        frame_start();
        expect_word(1, 0, 32'h53525150);
        expect_word(0, 1, 32'h57565554);
        expect_word(0, 0, 32'h5B5A5958);
        expect_word(0, 1, 32'h5F5E5D5C);
        for (int i = 0; i < 16; i++) pix(8'(8'h50 + i));
        for (int i = 0; i < 8; i++) pix(8'(8'h60 + i));
        drain();
        chk("done_fd", fd_cnt - fd0, 1);
        chk("done_tvalid", tvalid, 0);

        // 640-wide line with tready low: 16 kept, 144 dropped
        b_sensor = 1'b1;
        tick();
        for (int i = 0; i < 640; i++) begin
            b_ev = 1'b1;
            b_dout = 8'(i);
            tick();
        end
        b_ev = 1'b0;
        repeat (3) tick();
        chk("big_overflow_set", b_ovf, 1);
        chk("big_none_before", b_cnt, 0);
        b_tready = 1'b1;
        repeat (40) tick();
        chk("big_kept_count", b_cnt, 16);
        chk("big_word0", b_words[0], {2'b10, 32'h03020100});
        chk("big_word15", b_words[15], {2'b00, 32'h3F3E3D3C});
        $display("big line delivered %0d words, overflow=%0b", b_cnt, b_ovf);
        b_sensor = 1'b0;
        tick();
        b_sensor = 1'b1;
        tick();
        chk("big_overflow_clear", b_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
